string_accel_avalon: RTL



---
 rtl/string_accel_avalon.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/string_accel_avalon.sv
// string_accel_avalon: Avalon-MM string engine over A/B buffers into R/SCALAR.
// A word-serial FSM walks four chars per cycle for copy/case/len/cmp/find.
module string_accel_avalon #(
   parameter int MAX_WORDS    = 8,
   parameter int ADDRESS_BITS = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    chipselect,
   input  logic                    read,
   input  logic                    write,
   input  logic [ADDRESS_BITS-1:0] address,
   input  logic [31:0]             writedata,
   output logic [31:0]             readdata,
   output logic                    irq
);

   localparam int IW     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int A_BASE = 4;
   localparam int B_BASE = 4 + MAX_WORDS;
   localparam int R_BASE = 4 + 2 * MAX_WORDS;
   localparam int R_END  = 4 + 3 * MAX_WORDS;

   localparam logic [9:0]    CHARS  = 10'(4 * MAX_WORDS);
   localparam logic [IW-1:0] W_LAST = IW'(MAX_WORDS - 1);

   localparam logic [2:0] OP_COPY    = 3'd0;
   localparam logic [2:0] OP_UPPER   = 3'd1;
   localparam logic [2:0] OP_LOWER   = 3'd2;
   localparam logic [2:0] OP_STRLEN  = 3'd3;
   localparam logic [2:0] OP_STRCMP  = 3'd4;
   localparam logic [2:0] OP_FINDCHR = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FINISH
   } state_t;

   state_t state_q, state_d;

   logic [31:0] a_mem [MAX_WORDS];
   logic [31:0] b_mem [MAX_WORDS];
   logic [31:0] r_mem [MAX_WORDS];

   logic [2:0]    op_q;
   logic [7:0]    ch_q;
   logic [7:0]    limit_q;
   logic          irq_en_q;
   logic          done_q;
   logic          err_q;
   logic          wr_ign_q;
   logic [7:0]    words_q;
   logic [7:0]    n_q;
   logic [31:0]   scalar_q;
   logic [IW-1:0] w_q;

   logic        wr, rd, idle, busy;
   logic        go_ok, go_bad;
   logic [31:0] addr32;
   logic        sel_ctrl, sel_status, sel_scalar;
   logic        sel_a, sel_b, sel_r;
   logic [IW-1:0] a_idx, b_idx, r_idx;
   logic [31:0] rd_val;
   logic        unused_wd;

   assign wr     = chipselect & write;
   assign rd     = chipselect & read;
   assign idle   = (state_q == S_IDLE);
   assign busy   = !idle;
   assign addr32 = 32'(address);

   assign sel_ctrl   = (addr32 == 32'd0);
   assign sel_status = (addr32 == 32'd1);
   assign sel_scalar = (addr32 == 32'd2);
   assign sel_a = (addr32 >= 32'(A_BASE)) && (addr32 < 32'(B_BASE));
   assign sel_b = (addr32 >= 32'(B_BASE)) && (addr32 < 32'(R_BASE));
   assign sel_r = (addr32 >= 32'(R_BASE)) && (addr32 < 32'(R_END));

   assign a_idx = IW'(addr32 - 32'(A_BASE));
   assign b_idx = IW'(addr32 - 32'(B_BASE));
   assign r_idx = IW'(addr32 - 32'(R_BASE));

   assign go_ok  = wr && sel_ctrl && idle && writedata[0]
                   && (writedata[3:1] <= OP_FINDCHR);
   assign go_bad = wr && sel_ctrl && idle && writedata[0]
                   && (writedata[3:1] > OP_FINDCHR);

   assign unused_wd = ^{writedata[31], writedata[29:25], writedata[7:4]};

   assign irq = done_q & irq_en_q;

   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         sel_ctrl:   rd_val = {7'd0, irq_en_q, limit_q, ch_q,
                               4'd0, op_q, 1'b0};
         sel_status: rd_val = {16'd0, words_q, 4'd0,
                               wr_ign_q, err_q, busy, done_q};
         sel_scalar: rd_val = scalar_q;
         sel_a:      rd_val = a_mem[a_idx];
         sel_b:      rd_val = b_mem[b_idx];
         sel_r:      rd_val = r_mem[r_idx];
         default:    rd_val = '0;
      endcase
   end

   // Per-word datapath: classify each of the four bytes of word w_q.
   logic [9:0]  lmax, base, idx;
   logic [31:0] a_w, b_w, r_w, scalar_d;
   logic [7:0]  ab, bb, xb, d_a, d_b;
   logic        t_found, d_found, h_found, d_past, live, last;
   logic [1:0]  t_pos, h_pos;
   logic        exit_run;

   assign lmax = (limit_q == 8'h00 || {2'b00, limit_q} > CHARS)
                 ? CHARS : {2'b00, limit_q};

   always_comb begin
      a_w      = a_mem[w_q];
      b_w      = b_mem[w_q];
      base     = 10'({w_q, 2'b00});
      r_w      = '0;
      ab       = '0;
      bb       = '0;
      xb       = '0;
      idx      = '0;
      d_a      = '0;
      d_b      = '0;
      d_past   = 1'b0;
      t_found  = 1'b0;
      d_found  = 1'b0;
      h_found  = 1'b0;
      t_pos    = '0;
      h_pos    = '0;
      live     = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ab  = a_w[8*k +: 8];
         bb  = b_w[8*k +: 8];
         idx = base + 10'(k);
         if (!t_found && (ab == 8'h00 || idx >= lmax)) begin
            t_found = 1'b1;
            t_pos   = 2'(k);
         end
         live = !t_found;
         if (!d_found && (idx >= lmax || ab != bb || ab == 8'h00)) begin
            d_found = 1'b1;
            d_a     = ab;
            d_b     = bb;
            d_past  = (idx >= lmax);
         end
         if (!h_found && live && ab == ch_q) begin
            h_found = 1'b1;
            h_pos   = 2'(k);
         end
         xb = ab;
         if (op_q == OP_UPPER && ab >= 8'h61 && ab <= 8'h7A)
            xb = ab - 8'h20;
         if (op_q == OP_LOWER && ab >= 8'h41 && ab <= 8'h5A)
            xb = ab + 8'h20;
         r_w[8*k +: 8] = live ? xb : 8'h00;
      end

      last     = (w_q == W_LAST);
      exit_run = t_found || last;
      scalar_d = scalar_q;
      case (op_q)
         OP_STRLEN:
            scalar_d = t_found ? 32'(base + 10'(t_pos)) : 32'(lmax);
         OP_STRCMP: begin
            exit_run = d_found || last;
            if (d_found && !d_past && d_a > d_b)
               scalar_d = 32'd1;
            else if (d_found && !d_past && d_a < d_b)
               scalar_d = '1;
            else
               scalar_d = '0;
         end
         OP_FINDCHR: begin
            exit_run = h_found || t_found || last;
            scalar_d = h_found ? 32'(base + 10'(h_pos)) : '1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (go_ok) state_d = S_RUN;
         S_RUN:    if (exit_run) state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MAX_WORDS; i++) begin
            a_mem[i] <= '0;
            b_mem[i] <= '0;
            r_mem[i] <= '0;
         end
         op_q     <= '0;
         ch_q     <= '0;
         limit_q  <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         wr_ign_q <= 1'b0;
         words_q  <= '0;
         n_q      <= '0;
         scalar_q <= '0;
         w_q      <= '0;
         readdata <= '0;
      end else begin
         if (rd) readdata <= rd_val;

         if (wr && sel_status) begin
            if (writedata[0]) done_q   <= 1'b0;
            if (writedata[2]) err_q    <= 1'b0;
            if (writedata[3]) wr_ign_q <= 1'b0;
         end
         if (wr && busy && (sel_ctrl || sel_a || sel_b))
            wr_ign_q <= 1'b1;

         if (wr && idle && sel_a) a_mem[a_idx] <= writedata;
         if (wr && idle && sel_b) b_mem[b_idx] <= writedata;

         if (wr && idle && sel_ctrl) begin
            op_q     <= writedata[3:1];
            ch_q     <= writedata[15:8];
            limit_q  <= writedata[23:16];
            irq_en_q <= writedata[24];
            if (writedata[30]) begin
               for (int i = 0; i < MAX_WORDS; i++) begin
                  a_mem[i] <= '0;
                  b_mem[i] <= '0;
                  r_mem[i] <= '0;
               end
               scalar_q <= '0;
            end
         end

         if (go_ok) begin
            for (int i = 0; i < MAX_WORDS; i++) r_mem[i] <= '0;
            scalar_q <= '0;
            done_q   <= 1'b0;
            w_q      <= '0;
         end
         if (go_bad) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
         end

         if (state_q == S_RUN) begin
            if (op_q <= OP_LOWER) r_mem[w_q] <= r_w;
            if (exit_run) begin
               scalar_q <= scalar_d;
               n_q      <= 8'(w_q) + 8'd1;
            end else begin
               w_q <= w_q + IW'(1);
            end
         end

         // Completion set is last so it beats a same-cycle W1C.
         if (state_q == S_FINISH) begin
            done_q  <= 1'b1;
            words_q <= n_q;
         end
      end
   end

endmodule
